control_unit: RTL and testbench
===============================

# control_unit

Multicycle control unit for the RISC-V datapath. It consumes the instruction fields from the IR and the branch flag from the ULA. It produces every enable and mux select the datapath needs: PC/IR load, register-file write, data-memory write, Mux1–Mux4 selects and the ULA operation. It steps through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK, so each instruction is sequenced in a single shared datapath.

## Interface
- MEM_LATENCY, 1: cycles spent in MEMORY per load/store; legal range is 1..8.
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- opcode  in  7  instruction bits [6:0] from IR.
- funct3  in  3  instruction bits [14:12].
- funct7b5  in  1  instruction bit 30, the ADD/SUB distinction.
- flag  in  1  ULA branch-taken flag.
- pc_load  out  1  PC r_enable.
- ir_load  out  1  IR r_enable.
- reg_we  out  1  register-file write enable.
- mem_we  out  1  data-memory write strobe.
- alu_src  out  1  Mux1 select: 0 = imm, 1 = doutB.
- alu_a_sel  out  1  Mux4 select: 0 = PC<<2, 1 = doutA.
- wb_sel  out  2  Mux2 select: 00 = mem dout, 01 = ALU, 10 = PC+4, 11 = PC+imm.
- pc_src  out  1  Mux3 select: 0 = PC+4, 1 = PC+imm.
- alu_op  out  2  ALU operation: 00 = add, 01 = sub, 10 = branch compare (funct3).
- state  out  3  current state, for debug.
- illegal  out  1  sticky, set on an undecodable instruction.

## Operation
- States and encodings: FETCH=0, DECODE=1, EXECUTE=2, MEMORY=3, WRITEBACK=4, HALT=5.
- Legal opcodes:
  - LOAD 0000011
  - STORE 0100011
  - R-type 0110011
  - ADDI 0010011
  - BRANCH 1100011, with funct3 in {000,001,100,101,110,111}
  - AUIPC 0010111
  - JAL 1101111
- Any other opcode, or a branch with funct3 010/011, is illegal.
- Outputs not named for a state are 0 in that state.
- FETCH: ir_load=1. Next state is DECODE.
- DECODE: latch opcode, funct3 and funct7b5 into internal registers. The register file reads during this cycle.
  - Illegal instruction → HALT.
  - Otherwise → EXECUTE.
- EXECUTE: all selects below are driven from the latched fields.
  - LOAD/STORE: alu_a_sel=1, alu_src=0, alu_op=00. Next state MEMORY.
  - R-type: alu_a_sel=1, alu_src=1, alu_op=01 if funct7b5 else 00. Next state WRITEBACK.
  - ADDI: alu_a_sel=1, alu_src=0, alu_op=00. Next state WRITEBACK.
  - AUIPC: alu_a_sel=0, alu_src=0, alu_op=00. Next state WRITEBACK.
  - JAL: next state WRITEBACK.
  - BRANCH: alu_a_sel=1, alu_src=1, alu_op=10, pc_load=1, pc_src=flag. pc_src is combinational from the live flag input. Next state FETCH.
- MEMORY: a down-counter loaded with MEM_LATENCY-1 on entry; the state exits when the count is 0.
  - STORE: mem_we=1 in the final MEMORY cycle only. pc_load=1 with pc_src=0 in that same cycle. Next state FETCH.
  - LOAD: next state WRITEBACK.
- WRITEBACK: reg_we=1, pc_load=1. Next state FETCH.
  - wb_sel by instruction: LOAD 00, R/ADDI 01, JAL 10, AUIPC 01 (the ALU computes PC<<2 + imm).
  - pc_src=1 for JAL, otherwise 0.
- HALT: all strobes 0 and illegal=1. The unit stays in HALT until reset.

## Timing
- Reset, sampled on a rising clock edge:
  - next state is FETCH;
  - latched fields and counter are 0;
  - illegal=0.
- While reset is high, every output except state is forced to 0.
- Reset asserted mid-instruction aborts the instruction. No reg_we or mem_we is issued in the reset cycle.
- Cycles per instruction:
  - BRANCH: 3.
  - R, ADDI, AUIPC, JAL: 4.
  - STORE: 3+MEM_LATENCY.
  - LOAD: 4+MEM_LATENCY.
- pc_load is asserted exactly once per instruction, in its final cycle. reg_we and mem_we are each at most a single-cycle pulse per instruction.
- Inputs change between DECODE and EXECUTE: ignored, because EXECUTE uses the latched fields. The only exception is flag, which is sampled live in the EXECUTE cycle.
- Counter: width $clog2(MEM_LATENCY+1). It never wraps, because it is reloaded on every MEMORY entry.

## Structure
- Package control_pkg holds:
  - the opcode constants (OP_LOAD, OP_STORE, OP_RTYPE, OP_ADDI, OP_BRANCH, OP_AUIPC, OP_JAL);
  - the state enum;
  - the wb_sel and alu_op encodings.
- Sub-module control_decoder: combinational. Maps (opcode, funct3) to an instruction class and a legal bit. It is used in DECODE for the next-state decision and in later states for output decode from the latched fields.

## Test plan
- ADD (opcode 0110011, funct7b5=0), then SUB (funct7b5=1). Required response:
  - states 0,1,2,4 for each instruction;
  - alu_op 00 then 01 in EXECUTE;
  - reg_we=1, wb_sel=01 and pc_load=1 in cycle 4 only.
- BEQ with flag=1, then BNE with flag=0. Required response:
  - 3 cycles each;
  - pc_load=1 in EXECUTE, with pc_src=1 and 0 respectively;
  - reg_we and mem_we never asserted.
- MEM_LATENCY=3:
  - LOAD takes 7 cycles, with reg_we and wb_sel=00 in the last cycle.
  - STORE takes 6 cycles, with mem_we high only in cycle 6, coincident with pc_load.
- JAL, then AUIPC. Required response:
  - JAL writeback: wb_sel=10, pc_src=1.
  - AUIPC: alu_a_sel=0 in EXECUTE, wb_sel=01 in writeback.
- opcode 1111111, then branch with funct3=010. Required response:
  - DECODE→HALT in both cases;
  - illegal=1 and all strobes 0 for 10+ cycles;
  - a reset pulse returns the unit to FETCH.
- Reset asserted in the MEMORY cycle of a STORE with MEM_LATENCY=2. Required response:
  - no mem_we pulse;
  - state=0 on the next cycle;
  - the next FETCH asserts ir_load=1.

Source files
------------

// File: rtl/control_pkg.sv
// Shared encodings for the multicycle control unit: opcodes, FSM states,
// instruction classes and the datapath mux/ALU select codes.
package control_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ADDI   = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [2:0] {
        ST_FETCH     = 3'd0,
        ST_DECODE    = 3'd1,
        ST_EXECUTE   = 3'd2,
        ST_MEMORY    = 3'd3,
        ST_WRITEBACK = 3'd4,
        ST_HALT      = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        CLS_NONE,
        CLS_LOAD,
        CLS_STORE,
        CLS_RTYPE,
        CLS_ADDI,
        CLS_BRANCH,
        CLS_AUIPC,
        CLS_JAL
    } instr_cls_t;

    typedef enum logic [1:0] {
        WB_MEM   = 2'b00,
        WB_ALU   = 2'b01,
        WB_PC4   = 2'b10,
        WB_PCIMM = 2'b11
    } wb_sel_t;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_BR  = 2'b10
    } alu_op_t;

endpackage

// File: rtl/control_unit_if.sv
// Bundle between the control unit (master) and the datapath (slave):
// instruction fields and branch flag in, enables and mux selects out.
interface control_unit_if;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       flag;
    logic       pc_load;
    logic       ir_load;
    logic       reg_we;
    logic       mem_we;
    logic       alu_src;
    logic       alu_a_sel;
    logic [1:0] wb_sel;
    logic       pc_src;
    logic [1:0] alu_op;
    logic [2:0] state;
    logic       illegal;

    modport master (
        input  opcode, funct3, funct7b5, flag,
        output pc_load, ir_load, reg_we, mem_we, alu_src, alu_a_sel,
               wb_sel, pc_src, alu_op, state, illegal
    );

    modport slave (
        output opcode, funct3, funct7b5, flag,
        input  pc_load, ir_load, reg_we, mem_we, alu_src, alu_a_sel,
               wb_sel, pc_src, alu_op, state, illegal
    );
endinterface

// File: rtl/control_decoder.sv
// Combinational instruction classifier: (opcode, funct3) -> class + legal bit.
module control_decoder
    import control_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    output instr_cls_t cls,
    output logic       legal
);

    always_comb begin
        cls   = CLS_NONE;
        legal = 1'b1;
        case (opcode)
            OP_LOAD:   cls = CLS_LOAD;
            OP_STORE:  cls = CLS_STORE;
            OP_RTYPE:  cls = CLS_RTYPE;
            OP_ADDI:   cls = CLS_ADDI;
            OP_AUIPC:  cls = CLS_AUIPC;
            OP_JAL:    cls = CLS_JAL;
            OP_BRANCH: begin
                cls   = CLS_BRANCH;
                // funct3 010/011 have no branch meaning
                legal = (funct3 != 3'b010) && (funct3 != 3'b011);
            end
            default:   legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Multicycle FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK sequencer driving the
// shared RISC-V datapath's enables and mux selects.
module control_unit
    import control_pkg::*;
#(
    parameter int MEM_LATENCY = 1
) (
    input  logic           clock,
    input  logic           reset,
    control_unit_if.master bus
);

    localparam int CNT_W = $clog2(MEM_LATENCY + 1);

    state_t           state_q, state_d;
    logic [6:0]       op_q;
    logic [2:0]       f3_q;
    logic             f7b5_q;
    logic [CNT_W-1:0] cnt_q;
    logic             illegal_q;
    instr_cls_t       cls;
    logic             legal;
    logic [6:0]       dec_op;
    logic [2:0]       dec_f3;

    // DECODE classifies the live IR; every later state works from the latched copy
    assign dec_op = (state_q == ST_DECODE) ? bus.opcode : op_q;
    assign dec_f3 = (state_q == ST_DECODE) ? bus.funct3 : f3_q;

    control_decoder u_dec (
        .opcode (dec_op),
        .funct3 (dec_f3),
        .cls    (cls),
        .legal  (legal)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_FETCH;
            op_q      <= '0;
            f3_q      <= '0;
            f7b5_q    <= 1'b0;
            cnt_q     <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_DECODE) begin
                op_q   <= bus.opcode;
                f3_q   <= bus.funct3;
                f7b5_q <= bus.funct7b5;
                if (!legal) illegal_q <= 1'b1;
            end
            if (state_q == ST_EXECUTE && state_d == ST_MEMORY)
                cnt_q <= CNT_W'(MEM_LATENCY - 1);
            else if (state_q == ST_MEMORY && cnt_q != '0)
                cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    always_comb begin
        state_d       = state_q;
        bus.pc_load   = 1'b0;
        bus.ir_load   = 1'b0;
        bus.reg_we    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.alu_src   = 1'b0;
        bus.alu_a_sel = 1'b0;
        bus.wb_sel    = WB_MEM;
        bus.pc_src    = 1'b0;
        bus.alu_op    = ALU_ADD;
        case (state_q)
            ST_FETCH: begin
                bus.ir_load = 1'b1;
                state_d     = ST_DECODE;
            end
            ST_DECODE: state_d = legal ? ST_EXECUTE : ST_HALT;
            ST_EXECUTE: begin
                state_d = ST_WRITEBACK;
                case (cls)
                    CLS_LOAD, CLS_STORE: begin
                        bus.alu_a_sel = 1'b1;
                        state_d       = ST_MEMORY;
                    end
                    CLS_RTYPE: begin
                        bus.alu_a_sel = 1'b1;
                        bus.alu_src   = 1'b1;
                        bus.alu_op    = f7b5_q ? ALU_SUB : ALU_ADD;
                    end
                    CLS_ADDI: bus.alu_a_sel = 1'b1;
                    CLS_BRANCH: begin
                        // branch resolves here from the live ULA flag
                        bus.alu_a_sel = 1'b1;
                        bus.alu_src   = 1'b1;
                        bus.alu_op    = ALU_BR;
                        bus.pc_load   = 1'b1;
                        bus.pc_src    = bus.flag;
                        state_d       = ST_FETCH;
                    end
                    default: ;
                endcase
            end
            ST_MEMORY: begin
                if (cnt_q == '0) begin
                    if (cls == CLS_STORE) begin
                        bus.mem_we  = 1'b1;
                        bus.pc_load = 1'b1;
                        state_d     = ST_FETCH;
                    end else begin
                        state_d = ST_WRITEBACK;
                    end
                end
            end
            ST_WRITEBACK: begin
                bus.reg_we  = 1'b1;
                bus.pc_load = 1'b1;
                state_d     = ST_FETCH;
                case (cls)
                    CLS_LOAD: bus.wb_sel = WB_MEM;
                    CLS_JAL: begin
                        bus.wb_sel = WB_PC4;
                        bus.pc_src = 1'b1;
                    end
                    default:  bus.wb_sel = WB_ALU;
                endcase
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_FETCH;
        endcase
        // a reset cycle must never leak a strobe, even mid-instruction
        if (reset) begin
            bus.pc_load   = 1'b0;
            bus.ir_load   = 1'b0;
            bus.reg_we    = 1'b0;
            bus.mem_we    = 1'b0;
            bus.alu_src   = 1'b0;
            bus.alu_a_sel = 1'b0;
            bus.wb_sel    = WB_MEM;
            bus.pc_src    = 1'b0;
            bus.alu_op    = ALU_ADD;
        end
    end

    assign bus.state   = state_q;
    assign bus.illegal = illegal_q & ~reset;

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: per-cycle expected output words are
// queued when an instruction is driven and compared on each falling edge.
module tb_control_unit;

    typedef struct packed {
        logic [2:0] st;
        logic       pc_load;
        logic       ir_load;
        logic       reg_we;
        logic       mem_we;
        logic       alu_src;
        logic       alu_a_sel;
        logic [1:0] wb_sel;
        logic       pc_src;
        logic [1:0] alu_op;
        logic       illegal;
    } outs_t;

    typedef struct {
        string      name;
        logic [6:0] op;
        logic [2:0] f3;
        logic       f7;
        logic       flag;
        int         ncyc;
        outs_t      exe;
        outs_t      last;
    } vec_t;

    logic  clk = 1'b0;
    logic  rst1 = 1'b1;
    logic  rst2 = 1'b1;
    int    checks = 0;
    int    errors = 0;
    outs_t sb[$];
    outs_t act1, act2;
    vec_t  vt[11];

    control_unit_if bus1();
    control_unit_if bus2();

    control_unit #(.MEM_LATENCY(3)) dut1 (.clock(clk), .reset(rst1), .bus(bus1));
    control_unit #(.MEM_LATENCY(2)) dut2 (.clock(clk), .reset(rst2), .bus(bus2));

    always #5 clk = ~clk;

    assign act1 = {bus1.state, bus1.pc_load, bus1.ir_load, bus1.reg_we, bus1.mem_we,
                   bus1.alu_src, bus1.alu_a_sel, bus1.wb_sel, bus1.pc_src, bus1.alu_op,
                   bus1.illegal};
    assign act2 = {bus2.state, bus2.pc_load, bus2.ir_load, bus2.reg_we, bus2.mem_we,
                   bus2.alu_src, bus2.alu_a_sel, bus2.wb_sel, bus2.pc_src, bus2.alu_op,
                   bus2.illegal};

    function automatic outs_t mk(input int st, pcl, irl, rwe, mwe, asrc, asel, wb, psrc,
                                 aop, ill);
        outs_t o;
        o.st        = 3'(st);
        o.pc_load   = 1'(pcl);
        o.ir_load   = 1'(irl);
        o.reg_we    = 1'(rwe);
        o.mem_we    = 1'(mwe);
        o.alu_src   = 1'(asrc);
        o.alu_a_sel = 1'(asel);
        o.wb_sel    = 2'(wb);
        o.pc_src    = 1'(psrc);
        o.alu_op    = 2'(aop);
        o.illegal   = 1'(ill);
        return o;
    endfunction

    function automatic vec_t mkv(input string n, input logic [6:0] op, input logic [2:0] f3,
                                 input logic f7, input logic fl, input int nc,
                                 input outs_t e, input outs_t l);
        vec_t v;
        v.name = n; v.op = op; v.f3 = f3; v.f7 = f7; v.flag = fl;
        v.ncyc = nc; v.exe = e; v.last = l;
        return v;
    endfunction

    // Compare one cycle at the falling edge, then advance to just after the next rising edge.
    task automatic step_check(input string tag, input int sel);
        outs_t exp, got;
        @(negedge clk);
        got = (sel == 2) ? act2 : act1;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s scoreboard empty, got %h", tag, got);
        end else begin
            exp = sb.pop_front();
            if (got !== exp) begin
                errors++;
                $display("FAIL %s got %h want %h", tag, got, exp);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input vec_t v);
        bus1.opcode   = v.op;
        bus1.funct3   = v.f3;
        bus1.funct7b5 = v.f7;
        bus1.flag     = ~v.flag;
        sb.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        sb.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        sb.push_back(v.exe);
        for (int c = 4; c < v.ncyc; c++) sb.push_back(mk(3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        if (v.ncyc > 3) sb.push_back(v.last);
        for (int c = 1; c <= v.ncyc; c++) begin
            // after DECODE the fields are garbage; only flag matters, and only in EXECUTE
            if (c >= 3) begin
                bus1.opcode   = 7'h7f;
                bus1.funct3   = 3'b010;
                bus1.funct7b5 = ~v.f7;
                bus1.flag     = (c == 3) ? v.flag : ~v.flag;
            end
            step_check($sformatf("%s c%0d", v.name, c), 1);
        end
    endtask

    task automatic run_illegal(input string name, input logic [6:0] op, input logic [2:0] f3);
        bus1.opcode   = op;
        bus1.funct3   = f3;
        bus1.funct7b5 = 1'b0;
        bus1.flag     = 1'b1;
        sb.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        sb.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 12; i++) sb.push_back(mk(5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        for (int c = 1; c <= 14; c++) step_check($sformatf("%s c%0d", name, c), 1);
        rst1 = 1'b1;
        sb.push_back(mk(5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        step_check($sformatf("%s reset", name), 1);
        rst1 = 1'b0;
    endtask

    initial begin
        outs_t rwb, ls_exe;
        rwb    = mk(4, 1, 0, 1, 0, 0, 0, 1, 0, 0, 0);
        ls_exe = mk(2, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        vt[0]  = mkv("ADD",   7'b0110011, 3'b000, 1'b0, 1'b0, 4,
                     mk(2, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0), rwb);
        vt[1]  = mkv("SUB",   7'b0110011, 3'b000, 1'b1, 1'b0, 4,
                     mk(2, 0, 0, 0, 0, 1, 1, 0, 0, 1, 0), rwb);
        vt[2]  = mkv("BEQ",   7'b1100011, 3'b000, 1'b0, 1'b1, 3,
                     mk(2, 1, 0, 0, 0, 1, 1, 0, 1, 2, 0), mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vt[3]  = mkv("BNE",   7'b1100011, 3'b001, 1'b0, 1'b0, 3,
                     mk(2, 1, 0, 0, 0, 1, 1, 0, 0, 2, 0), mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vt[4]  = mkv("BLT",   7'b1100011, 3'b100, 1'b1, 1'b1, 3,
                     mk(2, 1, 0, 0, 0, 1, 1, 0, 1, 2, 0), mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vt[5]  = mkv("BGEU",  7'b1100011, 3'b111, 1'b0, 1'b0, 3,
                     mk(2, 1, 0, 0, 0, 1, 1, 0, 0, 2, 0), mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vt[6]  = mkv("LOAD",  7'b0000011, 3'b010, 1'b0, 1'b0, 7,
                     ls_exe, mk(4, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        vt[7]  = mkv("STORE", 7'b0100011, 3'b010, 1'b0, 1'b0, 6,
                     ls_exe, mk(3, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        vt[8]  = mkv("JAL",   7'b1101111, 3'b000, 1'b0, 1'b0, 4,
                     mk(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), mk(4, 1, 0, 1, 0, 0, 0, 2, 1, 0, 0));
        vt[9]  = mkv("AUIPC", 7'b0010111, 3'b000, 1'b1, 1'b1, 4,
                     mk(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), rwb);
        vt[10] = mkv("ADDI",  7'b0010011, 3'b000, 1'b1, 1'b0, 4,
                     mk(2, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0), rwb);

        bus1.opcode = '0; bus1.funct3 = '0; bus1.funct7b5 = 1'b0; bus1.flag = 1'b0;
        bus2.opcode = '0; bus2.funct3 = '0; bus2.funct7b5 = 1'b0; bus2.flag = 1'b0;

        @(posedge clk);
        #1;
        sb.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        step_check("reset state", 1);
        rst1 = 1'b0;

        for (int i = 0; i < 11; i++) run_vec(vt[i]);

        run_illegal("ILL opcode", 7'b1111111, 3'b000);
        run_illegal("ILL branch", 7'b1100011, 3'b010);
        run_vec(vt[0]);

        // STORE on the MEM_LATENCY=2 unit, reset lands in its final MEMORY cycle
        rst2 = 1'b0;
        bus2.opcode = 7'b0100011;
        bus2.funct3 = 3'b010;
        sb.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        sb.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        sb.push_back(ls_exe);
        sb.push_back(mk(3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        for (int c = 1; c <= 4; c++) step_check($sformatf("ST abort c%0d", c), 2);
        rst2 = 1'b1;
        sb.push_back(mk(3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        step_check("ST abort reset cycle", 2);
        rst2 = 1'b0;
        sb.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        step_check("ST abort refetch", 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
